// File: rtl/reg_file_mwp_if.sv
// rtl/reg_file_mwp_if.sv - bus bundle for the multi-write-port register file
// Purpose: groups the write ports, read port, clear control and register image.
// Ports (signals):
//   wen_in/waddr_in/be_in/d_in   per-port write enable, address, byte enables, data
//   rd_en_in/rd_addr_in          read request and address
//   rd_data_out/rd_valid_out     registered read data and its one-cycle valid
//   clr_req_in/clr_busy_out      clear sequence request and in-progress flag
//   wr_drop_out                  pulse when an enabled write was discarded
//   a_out                        flat image of all registers, reg0 in the top slice
// Modports: master drives requests, slave is the register file.
interface reg_file_mwp_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int NUM_WP   = 2,
    parameter int BYTE_W   = 8
);
    localparam int NB = DATA_W / BYTE_W;

    logic [NUM_WP-1:0]          wen_in;
    logic [NUM_WP*ADDR_W-1:0]   waddr_in;
    logic [NUM_WP*NB-1:0]       be_in;
    logic [NUM_WP*DATA_W-1:0]   d_in;
    logic                       rd_en_in;
    logic [ADDR_W-1:0]          rd_addr_in;
    logic [DATA_W-1:0]          rd_data_out;
    logic                       rd_valid_out;
    logic                       clr_req_in;
    logic                       clr_busy_out;
    logic                       wr_drop_out;
    logic [NUM_REGS*DATA_W-1:0] a_out;

    modport master (
        output wen_in, waddr_in, be_in, d_in, rd_en_in, rd_addr_in, clr_req_in,
        input  rd_data_out, rd_valid_out, clr_busy_out, wr_drop_out, a_out
    );

    modport slave (
        input  wen_in, waddr_in, be_in, d_in, rd_en_in, rd_addr_in, clr_req_in,
        output rd_data_out, rd_valid_out, clr_busy_out, wr_drop_out, a_out
    );
endinterface

// File: rtl/reg_file_mwp.sv
// rtl/reg_file_mwp.sv - register file with byte-enabled write ports and a clear engine
// Purpose: NUM_REGS x DATA_W registers, NUM_WP byte-enabled write ports (highest
//   port wins per lane), one registered read port returning pre-edge data, a flat
//   register image, and a sequencer that zeroes one register per cycle.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    reg_file_mwp_if.slave (write ports, read port, clear control, a_out)
module reg_file_mwp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int NUM_WP   = 2,
    parameter int BYTE_W   = 8
) (
    input  logic           clock,
    input  logic           reset,
    reg_file_mwp_if.slave  bus
);
    localparam int NB = DATA_W / BYTE_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] regs_next [NUM_REGS];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              drop_next;
    logic              drop;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (bus.clr_req_in) begin
                    state_next = CLEARING;
                    ptr_next   = '0;
                end
            end
            CLEARING: begin
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Ports are applied in ascending order so a later (higher) port overwrites
    // a colliding lane. Out-of-range addresses match no register and only flag a drop.
    always_comb begin
        drop_next = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
        end
        if (state == CLEARING) begin
            drop_next = |bus.wen_in;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ptr == ADDR_W'(i)) begin
                    regs_next[i] = '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_WP; p++) begin
                if (bus.wen_in[p]) begin
                    if ({1'b0, bus.waddr_in[p*ADDR_W +: ADDR_W]} >= (ADDR_W+1)'(NUM_REGS)) begin
                        drop_next = 1'b1;
                    end
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (bus.waddr_in[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                            for (int b = 0; b < NB; b++) begin
                                if (bus.be_in[p*NB + b]) begin
                                    regs_next[i][b*BYTE_W +: BYTE_W] =
                                        bus.d_in[p*DATA_W + b*BYTE_W +: BYTE_W];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_in == ADDR_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            drop     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            rd_valid <= bus.rd_en_in;
            drop     <= drop_next;
            if (bus.rd_en_in) begin
                rd_data <= rd_word;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_next[i];
            end
        end
    end

    assign bus.rd_data_out  = rd_data;
    assign bus.rd_valid_out = rd_valid;
    assign bus.wr_drop_out  = drop;
    assign bus.clr_busy_out = (state == CLEARING);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_image
        assign bus.a_out[DATA_W*(NUM_REGS-1-g) +: DATA_W] = regs[g];
    end
endmodule

// File: tb/tb_reg_file_mwp.sv
// tb/tb_reg_file_mwp.sv - self-checking bench for reg_file_mwp
module tb_reg_file_mwp;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    bit   chk_en;

    reg_file_mwp_if #(.NUM_REGS(4)) ifb ();
    reg_file_mwp_if #(.NUM_REGS(3)) ifs ();

    reg_file_mwp #(.NUM_REGS(4)) dut   (.clock(clock), .reset(reset), .bus(ifb.slave));
    reg_file_mwp #(.NUM_REGS(3)) dut_s (.clock(clock), .reset(reset), .bus(ifs.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: register contents, pending read result, and how many
    // registers the clear sequence still has to zero.
    logic [15:0] m_regs [4];
    logic [15:0] m_rd_data;
    logic        m_rd_valid;
    logic        m_drop;
    int          m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_image();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*(3-i) +: 16] = m_regs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_rd_data  = 16'h0;
        m_rd_valid = 1'b0;
        m_drop     = 1'b0;
        m_left     = 0;
    endtask

    task automatic idle();
        ifb.wen_in = '0; ifb.waddr_in = '0; ifb.be_in = '0; ifb.d_in = '0;
        ifb.rd_en_in = 1'b0; ifb.rd_addr_in = '0; ifb.clr_req_in = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [1:0] be, input logic [15:0] d);
        logic [1:0] a2;
        a2 = a[1:0];
        ifb.wen_in[p]           = 1'b1;
        ifb.waddr_in[p*2 +: 2]  = a2;
        ifb.be_in[p*2 +: 2]     = be;
        ifb.d_in[p*16 +: 16]    = d;
    endtask

    task automatic rd(input int a);
        logic [1:0] a2;
        a2 = a[1:0];
        ifb.rd_en_in   = 1'b1;
        ifb.rd_addr_in = a2;
    endtask

    // One clock: compute the reference outcome from the inputs now on the bus,
    // cross the edge, then publish it for the compare process.
    task automatic step();
        logic [15:0] nr [4];
        logic [15:0] nrd;
        logic        nv, nd;
        int          nl, wa;
        nr  = m_regs;
        nrd = m_rd_data;
        nv  = ifb.rd_en_in;
        nd  = 1'b0;
        nl  = m_left;
        if (ifb.rd_en_in) nrd = m_regs[int'(ifb.rd_addr_in)];
        if (m_left > 0) begin
            nd = |ifb.wen_in;
            nr[4 - m_left] = 16'h0;
            nl = m_left - 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ifb.wen_in[p]) begin
                    wa = int'(ifb.waddr_in[p*2 +: 2]);
                    for (int b = 0; b < 2; b++)
                        if (ifb.be_in[p*2 + b]) nr[wa][b*8 +: 8] = ifb.d_in[p*16 + b*8 +: 8];
                end
            end
            if (ifb.clr_req_in) nl = 4;
        end
        @(posedge clock);
        #1;
        m_regs = nr; m_rd_data = nrd; m_rd_valid = nv; m_drop = nd; m_left = nl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_a_out", ifb.a_out, 64'h0);
        check("rst_rd_valid", ifb.rd_valid_out, 1'b0);
        check("rst_busy", ifb.clr_busy_out, 1'b0);
        check("rst_drop", ifb.wr_drop_out, 1'b0);
        @(posedge clock);
        #1;
        idle();
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_rd_valid", ifb.rd_valid_out, m_rd_valid);
            check("cyc_rd_data", ifb.rd_data_out, m_rd_data);
            check("cyc_busy", ifb.clr_busy_out, m_left > 0);
            check("cyc_drop", ifb.wr_drop_out, m_drop);
            check("cyc_a_out", ifb.a_out, model_image());
        end
    end

    int busy_cnt;

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        reset = 1'b1;
        idle();
        ifs.wen_in = '0; ifs.waddr_in = '0; ifs.be_in = '0; ifs.d_in = '0;
        ifs.rd_en_in = 1'b0; ifs.rd_addr_in = '0; ifs.clr_req_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Out of range on the 3-register instance.
        ifs.wen_in = 2'b01; ifs.waddr_in[1:0] = 2'd3; ifs.be_in[1:0] = 2'b11; ifs.d_in[15:0] = 16'hFFFF;
        step();
        check("oor_drop", ifs.wr_drop_out, 1'b1);
        check("oor_a_out", ifs.a_out, 48'h0);
        ifs.wen_in = 2'b01; ifs.waddr_in[1:0] = 2'd2; ifs.d_in[15:0] = 16'h1234;
        ifs.rd_en_in = 1'b1; ifs.rd_addr_in = 2'd3;
        step();
        check("oor_rd_data", ifs.rd_data_out, 16'h0);
        check("oor_rd_valid", ifs.rd_valid_out, 1'b1);
        check("oor_inrange_a_out", ifs.a_out, 48'h0000_0000_1234);
        check("oor_inrange_drop", ifs.wr_drop_out, 1'b0);
        ifs.wen_in = '0; ifs.rd_en_in = 1'b0;

        // Reset mid-use.
        idle(); wr(0, 1, 2'b11, 16'hBEEF); step();
        check("beef_reg1", ifb.a_out[32 +: 16], 16'hBEEF);
        do_reset();

        // Byte enables.
        idle(); wr(0, 2, 2'b11, 16'h1234); step();
        idle(); wr(0, 2, 2'b10, 16'hAB00); step();
        idle();
        check("be_model_reg2", m_regs[2], 16'hAB34);
        check("be_reg2", ifb.a_out[16 +: 16], 16'hAB34);
        rd(2); step(); idle();
        check("be_rd", ifb.rd_data_out, 16'hAB34);

        // Collisions.
        wr(0, 3, 2'b11, 16'h1111); wr(1, 3, 2'b11, 16'h2222); step(); idle();
        check("coll_reg3", ifb.a_out[0 +: 16], 16'h2222);
        wr(0, 3, 2'b01, 16'h1111); wr(1, 3, 2'b10, 16'h2222); step(); idle();
        check("split_reg3", ifb.a_out[0 +: 16], 16'h2211);

        // Read during write returns old data.
        wr(0, 0, 2'b11, 16'h0005); step(); idle();
        wr(0, 0, 2'b11, 16'h0009); rd(0); step(); idle();
        check("rdw_old", ifb.rd_data_out, 16'h0005);
        rd(0); step(); idle();
        check("rdw_new", ifb.rd_data_out, 16'h0009);

        // Clear sequence with a discarded write.
        for (int i = 0; i < 4; i++) begin
            idle(); wr(0, i, 2'b11, 16'hA0A0 + 16'(i)); step();
        end
        idle(); ifb.clr_req_in = 1'b1; step(); idle();
        busy_cnt = int'(ifb.clr_busy_out);
        wr(0, 1, 2'b11, 16'h5555); step(); idle();
        check("clr_drop", ifb.wr_drop_out, 1'b1);
        busy_cnt += int'(ifb.clr_busy_out);
        repeat (5) begin
            step();
            busy_cnt += int'(ifb.clr_busy_out);
        end
        check("clr_busy_len", 32'(busy_cnt), 32'd4);
        check("clr_a_out", ifb.a_out, 64'h0);

        // Reset on the 2nd busy cycle.
        wr(0, 2, 2'b11, 16'h7777); step(); idle();
        ifb.clr_req_in = 1'b1; step(); idle();
        step();
        check("clr2_busy", ifb.clr_busy_out, 1'b1);
        do_reset();
        check("clr2_idle", ifb.clr_busy_out, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            for (int p = 0; p < 2; p++)
                if ($urandom_range(2) == 0)
                    wr(p, int'($urandom_range(3)), 2'($urandom_range(3)), 16'($urandom));
            if ($urandom_range(1) == 1) rd(int'($urandom_range(3)));
            ifb.clr_req_in = ($urandom_range(19) == 0);
            if ($urandom_range(199) == 0) do_reset();
            else step();
        end
        idle();
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
